// File: rtl/data_mem_unit.sv
// Data memory unit: byte/half/word loads and stores with fixed wait states,
// alignment checking and load sign/zero extension.
module data_mem_unit #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        busy,
    output logic        misalign,
    output logic [31:0] ram_result
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      size_q;
    logic            we_q, sign_ext_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            misaligned_c, capture_c, access_c, mis_set_c;
    logic            mem_we_c, load_c;
    logic [31:0]     rd_word_c, ld_val_c, wr_data_c;
    logic [3:0]      wr_be_c;
    logic [7:0]      ld_byte_c;
    logic [15:0]     ld_half_c;
    logic            unused_addr_bits;

    // Address bits above the memory window are ignored, so accesses wrap.
    assign unused_addr_bits = ^addr[31:AW+2];

    assign misaligned_c = (size == 2'b11)
                        | ((size == 2'b01) & addr[0])
                        | ((size == 2'b10) & (addr[1:0] != 2'b00));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture_c  = 1'b0;
        access_c   = 1'b0;
        mis_set_c  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture_c = 1'b1;
                    if (misaligned_c) begin
                        state_next = DONE;
                        mis_set_c  = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CW'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access_c   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mem_we_c  = access_c & we_q;
    assign load_c    = access_c & ~we_q;
    assign rd_word_c = mem[addr_q[AW+1:2]];

    // Lane selection and extension of load data
    always_comb begin
        ld_byte_c = rd_word_c[7:0];
        case (addr_q[1:0])
            2'd0:    ld_byte_c = rd_word_c[7:0];
            2'd1:    ld_byte_c = rd_word_c[15:8];
            2'd2:    ld_byte_c = rd_word_c[23:16];
            default: ld_byte_c = rd_word_c[31:24];
        endcase
        ld_half_c = addr_q[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        case (size_q)
            2'b00:   ld_val_c = sign_ext_q ? {{24{ld_byte_c[7]}}, ld_byte_c}
                                           : {24'd0, ld_byte_c};
            2'b01:   ld_val_c = sign_ext_q ? {{16{ld_half_c[15]}}, ld_half_c}
                                           : {16'd0, ld_half_c};
            default: ld_val_c = rd_word_c;
        endcase
    end

    // Store data replicated across lanes; byte enables pick the target lanes
    always_comb begin
        wr_data_c = wdata_q;
        wr_be_c   = 4'b1111;
        case (size_q)
            2'b00: begin
                wr_data_c = {4{wdata_q[7:0]}};
                wr_be_c   = 4'(4'b0001 << addr_q[1:0]);
            end
            2'b01: begin
                wr_data_c = {2{wdata_q[15:0]}};
                wr_be_c   = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data_c = wdata_q;
                wr_be_c   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            misalign   <= 1'b0;
            ram_result <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            sign_ext_q <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ready    <= (state_next == DONE);
            busy     <= (state_next != IDLE);
            misalign <= mis_set_c;
            if (capture_c) begin
                addr_q     <= addr[AW+1:0];
                wdata_q    <= wdata;
                size_q     <= size;
                we_q       <= we;
                sign_ext_q <= sign_ext;
            end
            if (mis_set_c) begin
                ram_result <= '0;
            end else if (load_c) begin
                ram_result <= ld_val_c;
            end
        end
    end

    // Memory array is intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be_c[k]) begin
                    mem[addr_q[AW+1:2]][8*k +: 8] <= wr_data_c[8*k +: 8];
                end
            end
        end
    end
endmodule
